// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared BCD types, FSM states and add-3 helper
package bcd_pkg;

    localparam int BCD_DIGIT_W = 4;

    typedef logic [BCD_DIGIT_W-1:0] bcd_digit_t;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } b2b_state_t;

    // Pre-shift correction so a digit >= 5 carries cleanly into the next digit after doubling.
    function automatic bcd_digit_t bcd_adj3(input bcd_digit_t d);
        return (d > 4'd4) ? bcd_digit_t'(d + 4'd3) : d;
    endfunction

endpackage

// File: rtl/bin2bcd_seq_if.sv
// rtl/bin2bcd_seq_if.sv - converter handshake bundle; blank present only with BIN2BCD_BLANK_EN
interface bin2bcd_seq_if #(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5
);
    logic                  in_valid;
    logic                  in_ready;
    logic [BIN_W-1:0]      bin;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   bcd;
    logic                  ovf;
`ifdef BIN2BCD_BLANK_EN
    logic [DIGITS-1:0]     blank;

    modport master (
        output in_valid, bin, out_ready,
        input  in_ready, out_valid, bcd, ovf, blank
    );

    modport slave (
        input  in_valid, bin, out_ready,
        output in_ready, out_valid, bcd, ovf, blank
    );
`else
    modport master (
        output in_valid, bin, out_ready,
        input  in_ready, out_valid, bcd, ovf
    );

    modport slave (
        input  in_valid, bin, out_ready,
        output in_ready, out_valid, bcd, ovf
    );
`endif
endinterface

// File: rtl/bcd_digit_adj.sv
// rtl/bcd_digit_adj.sv - combinational add-3 cell for one BCD digit
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  bcd_digit_t d,
    output bcd_digit_t q
);

    assign q = bcd_adj3(d);

endmodule

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential shift-and-add-3 binary to BCD converter; optional BIN2BCD_BLANK_EN
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    bin2bcd_seq_if.slave  bus
);

    localparam int CNT_W = $clog2(BIN_W);
    localparam int BCD_W = BCD_DIGIT_W * DIGITS;

    b2b_state_t        state;
    logic [BIN_W-1:0]  sh;
    logic [BCD_W-1:0]  bcd_q;
    logic [BCD_W-1:0]  bcd_adj;
    logic [CNT_W-1:0]  cnt;
    logic              ovf_q;
    logic              out_valid_q;
    logic              idle_q;
    logic              take;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .d (bcd_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .q (bcd_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    // A finished result leaving this edge frees the converter for a same-edge reload.
    assign take         = out_valid_q & bus.out_ready;
    assign bus.in_ready = idle_q | take;
    assign bus.out_valid = out_valid_q;
    assign bus.bcd      = bcd_q;
    assign bus.ovf      = ovf_q;

`ifdef BIN2BCD_BLANK_EN
    logic [DIGITS-1:0] blank_q;
    logic [DIGITS-1:0] blank_nx;
    logic              zero_above;

    // Scan from the most significant digit down; the units digit always stays lit.
    always_comb begin
        blank_nx   = '0;
        zero_above = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            zero_above  = zero_above & (bcd_q[i*BCD_DIGIT_W +: BCD_DIGIT_W] == 4'd0);
            blank_nx[i] = zero_above;
        end
    end

    assign bus.blank = blank_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            idle_q      <= 1'b1;
            out_valid_q <= 1'b0;
            sh          <= '0;
            bcd_q       <= '0;
            cnt         <= '0;
            ovf_q       <= 1'b0;
`ifdef BIN2BCD_BLANK_EN
            blank_q     <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        sh     <= bus.bin;
                        bcd_q  <= '0;
                        ovf_q  <= 1'b0;
                        cnt    <= CNT_W'(BIN_W - 1);
                        idle_q <= 1'b0;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    bcd_q <= {bcd_adj[BCD_W-2:0], sh[BIN_W-1]};
                    sh    <= {sh[BIN_W-2:0], 1'b0};
                    ovf_q <= ovf_q | bcd_adj[BCD_W-1];
                    cnt   <= cnt - 1'b1;
                    if (cnt == '0) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    // First DONE cycle only publishes; the result is offered from the next edge on.
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
`ifdef BIN2BCD_BLANK_EN
                        blank_q     <= blank_nx;
`endif
                    end else if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
`ifdef BIN2BCD_BLANK_EN
                        blank_q     <= '0;
`endif
                        if (bus.in_valid) begin
                            sh    <= bus.bin;
                            bcd_q <= '0;
                            ovf_q <= 1'b0;
                            cnt   <= CNT_W'(BIN_W - 1);
                            state <= SHIFT;
                        end else begin
                            idle_q <= 1'b1;
                            state  <= IDLE;
                        end
                    end
                end
                default: begin
                    idle_q <= 1'b1;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb/tb_bin2bcd_seq.sv - directed bench for bin2bcd_seq in three sizes; blank checks with BIN2BCD_BLANK_EN
module tb_bin2bcd_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bin2bcd_seq_if #(.BIN_W(8),  .DIGITS(3)) ia ();
    bin2bcd_seq_if #(.BIN_W(16), .DIGITS(5)) ib ();
    bin2bcd_seq_if #(.BIN_W(8),  .DIGITS(2)) ic ();

    bin2bcd_seq #(.BIN_W(8),  .DIGITS(3)) u_a (.clk(clk), .rst_n(rst_n), .bus(ia.slave));
    bin2bcd_seq #(.BIN_W(16), .DIGITS(5)) u_b (.clk(clk), .rst_n(rst_n), .bus(ib.slave));
    bin2bcd_seq #(.BIN_W(8),  .DIGITS(2)) u_c (.clk(clk), .rst_n(rst_n), .bus(ic.slave));

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] ra_bcd, rb_bcd, rc_bcd;
    logic        ra_ovf, rb_ovf, rc_ovf;
    logic [31:0] ra_blank, rb_blank, rc_blank;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_bcd(input int unsigned v, input int d);
        logic [31:0] r;
        int unsigned x;
        r = '0;
        x = v;
        for (int i = 0; i < d; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [31:0] ref_ovf(input int unsigned v, input int d);
        longint unsigned lim;
        lim = 1;
        for (int i = 0; i < d; i++) lim = lim * 10;
        return (longint'(v) >= lim) ? 32'd1 : 32'd0;
    endfunction

    // Drives the same value into all three converters and scores latency and result of each.
    task automatic run_all(input logic [15:0] v);
        bit sa, sb, sc;
        int la, lb, lc;
        sa = 0; sb = 0; sc = 0; la = 0; lb = 0; lc = 0;
        @(negedge clk);
        ia.bin = v[7:0]; ib.bin = v; ic.bin = v[7:0];
        ia.in_valid = 1'b1; ib.in_valid = 1'b1; ic.in_valid = 1'b1;
        @(posedge clk);
        #1;
        ia.in_valid = 1'b0; ib.in_valid = 1'b0; ic.in_valid = 1'b0;
        for (int n = 1; n <= 40 && !(sa && sb && sc); n++) begin
            @(posedge clk);
            @(negedge clk);
            if (!sa && ia.out_valid) begin
                sa = 1; la = n; ra_bcd = 32'(ia.bcd); ra_ovf = ia.ovf;
`ifdef BIN2BCD_BLANK_EN
                ra_blank = 32'(ia.blank);
`endif
            end
            if (!sb && ib.out_valid) begin
                sb = 1; lb = n; rb_bcd = 32'(ib.bcd); rb_ovf = ib.ovf;
`ifdef BIN2BCD_BLANK_EN
                rb_blank = 32'(ib.blank);
`endif
            end
            if (!sc && ic.out_valid) begin
                sc = 1; lc = n; rc_bcd = 32'(ic.bcd); rc_ovf = ic.ovf;
`ifdef BIN2BCD_BLANK_EN
                rc_blank = 32'(ic.blank);
`endif
            end
        end
        check($sformatf("lat_a(%0d)", v), la, 9);
        check($sformatf("lat_b(%0d)", v), lb, 17);
        check($sformatf("lat_c(%0d)", v), lc, 9);
        check($sformatf("bcd_a(%0d)", v), ra_bcd, ref_bcd(int'(v[7:0]), 3));
        check($sformatf("bcd_b(%0d)", v), rb_bcd, ref_bcd(int'(v), 5));
        check($sformatf("bcd_c(%0d)", v), rc_bcd, ref_bcd(int'(v[7:0]), 2));
        check($sformatf("ovf_a(%0d)", v), 32'(ra_ovf), ref_ovf(int'(v[7:0]), 3));
        check($sformatf("ovf_b(%0d)", v), 32'(rb_ovf), ref_ovf(int'(v), 5));
        check($sformatf("ovf_c(%0d)", v), 32'(rc_ovf), ref_ovf(int'(v[7:0]), 2));
        @(posedge clk);
    endtask

    initial begin
        bit          seen;
        bit          stable;
        int          lat;
        logic [15:0] v;

        ra_blank = '0; rb_blank = '0; rc_blank = '0;
        ia.in_valid = 1'b0; ib.in_valid = 1'b0; ic.in_valid = 1'b0;
        ia.bin = '0; ib.bin = '0; ic.bin = '0;
        ia.out_ready = 1'b1; ib.out_ready = 1'b1; ic.out_ready = 1'b1;

        repeat (2) @(negedge clk);
        check("rst_in_ready_b", 32'(ib.in_ready), 1);
        check("rst_out_valid_b", 32'(ib.out_valid), 0);
        check("rst_bcd_b", 32'(ib.bcd), 0);
        check("rst_ovf_b", 32'(ib.ovf), 0);
        check("rst_in_ready_a", 32'(ia.in_ready), 1);
        check("rst_out_valid_c", 32'(ic.out_valid), 0);
`ifdef BIN2BCD_BLANK_EN
        check("rst_blank_b", 32'(ib.blank), 0);
`endif
        rst_n = 1'b1;

        run_all(16'd255);
        check("t1_255_a", ra_bcd, 32'h255);
        check("t1_255_a_ovf", 32'(ra_ovf), 0);
        run_all(16'd0);
        check("t1_0_a", ra_bcd, 32'h000);
        check("t1_0_b_ovf", 32'(rb_ovf), 0);
        run_all(16'd65535);
        check("t2_65535_b", rb_bcd, 32'h65535);
        run_all(16'd1234);
        check("t2_1234_b", rb_bcd, 32'h01234);
        run_all(16'd100);
        check("t3_100_c", rc_bcd, 32'h00);
        check("t3_100_c_ovf", 32'(rc_ovf), 1);
        run_all(16'd99);
        check("t3_99_c", rc_bcd, 32'h99);
        check("t3_99_c_ovf", 32'(rc_ovf), 0);

        // Backpressure on the 16-bit converter
        @(negedge clk);
        ib.out_ready = 1'b0; ib.bin = 16'd4321; ib.in_valid = 1'b1;
        @(posedge clk);
        #1 ib.in_valid = 1'b0;
        seen = 0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk);
            if (ib.out_valid) seen = 1;
        end
        check("bp_seen", 32'(seen), 1);
        stable = 1;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk);
            @(negedge clk);
            stable = stable & (ib.out_valid === 1'b1) & (ib.bcd === 20'h04321) & (ib.in_ready === 1'b0);
        end
        check("bp_stable", 32'(stable), 1);
        ib.bin = 16'd777; ib.in_valid = 1'b1; ib.out_ready = 1'b1;
        #1 check("bp_in_ready", 32'(ib.in_ready), 1);
        @(posedge clk);
        #1 ib.in_valid = 1'b0;
        check("bp_taken_out_valid", 32'(ib.out_valid), 0);
        check("bp_taken_in_ready", 32'(ib.in_ready), 0);
        lat = 0;
        for (int n = 1; n <= 40 && lat == 0; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (ib.out_valid) begin
                lat = n;
                rb_bcd = 32'(ib.bcd);
            end
        end
        check("bp_reload_lat", lat, 17);
        check("bp_reload_bcd", rb_bcd, 32'h00777);
        @(posedge clk);

        // Reset in the middle of a conversion
        @(negedge clk);
        ib.bin = 16'hFFFF; ib.in_valid = 1'b1;
        @(posedge clk);
        #1 ib.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 check("mid_bcd_b", 32'(ib.bcd), 32'h00031);
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 32'(ib.out_valid), 0);
        check("abort_in_ready", 32'(ib.in_ready), 1);
        check("abort_bcd", 32'(ib.bcd), 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_all(16'd9876);
        check("post_rst_b", rb_bcd, 32'h09876);

`ifdef BIN2BCD_BLANK_EN
        run_all(16'd42);
        check("blank_42_b", rb_blank, 32'b11100);
        check("blank_42_a", ra_blank, 32'b100);
        run_all(16'd0);
        check("blank_0_b", rb_blank, 32'b11110);
        check("blank_0_a", ra_blank, 32'b110);
        check("blank_0_c", rc_blank, 32'b10);
`endif

        // Random values with input noise during conversion and output stalls
        for (int k = 0; k < 24; k++) begin
            v = 16'($urandom_range(0, 65535));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            @(negedge clk);
            ib.bin = v; ib.in_valid = 1'b1; ib.out_ready = 1'b0;
            @(posedge clk);
            #1 ib.in_valid = 1'b0;
            seen = 0;
            for (int n = 0; n < 40 && !seen; n++) begin
                @(negedge clk);
                if (ib.out_valid) begin
                    seen = 1;
                end else begin
                    ib.in_valid = 1'($urandom_range(0, 1));
                    ib.bin = 16'($urandom_range(0, 65535));
                end
            end
            repeat ($urandom_range(0, 4)) @(negedge clk);
            check($sformatf("rnd_seen(%0d)", v), 32'(seen), 1);
            check($sformatf("rnd_bcd(%0d)", v), 32'(ib.bcd), ref_bcd(int'(v), 5));
            check($sformatf("rnd_ovf(%0d)", v), 32'(ib.ovf), 0);
            ib.in_valid = 1'b0; ib.out_ready = 1'b1;
            @(posedge clk);
            #1 ib.out_ready = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
